// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin REQ#/GNT# arbitration with bus parking,
// hidden arbitration during transactions and a grant-acceptance timeout.
module pci_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int PARK_MASTER = 0,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         req,
    output logic [NUM_MASTERS-1:0]         gnt,
    input  logic                           frame,
    input  logic                           irdy,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic                           owner_valid,
    output logic                           bus_busy
);

    localparam int OW = $clog2(NUM_MASTERS);
    localparam int TW = $clog2(GNT_TIMEOUT + 1);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("pci_bus_arbiter: NUM_MASTERS must be in 2..8");
    end
    if (PARK_MASTER < 0 || PARK_MASTER >= NUM_MASTERS) begin : g_bad_park_master
        $error("pci_bus_arbiter: PARK_MASTER must be below NUM_MASTERS");
    end
    if (GNT_TIMEOUT < 1) begin : g_bad_timeout
        $error("pci_bus_arbiter: GNT_TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_GNT,
        S_BUSY
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   gnt_q, gnt_d;
    logic [OW-1:0]            owner_q, owner_d;
    logic                     owner_valid_q, owner_valid_d;
    logic                     bus_busy_q;
    logic [OW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]            timer_q, timer_d;

    logic                     bus_idle;
    logic                     txn_start;
    logic                     any_req;
    logic                     other_req;
    logic [OW-1:0]            winner;
    logic [OW-1:0]            owner_inc;

    assign bus_idle  = frame & irdy;
    assign txn_start = ~frame & ~bus_busy_q;

    // Scanned from the highest offset down so the nearest requester after rr_ptr wins.
    always_comb begin
        int idx;
        winner  = rr_ptr_q;
        any_req = 1'b0;
        idx     = 0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_MASTERS;
            if (!req[idx]) begin
                winner  = OW'(idx);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        other_req = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!req[i] && (i != int'(owner_q))) begin
                other_req = 1'b1;
            end
        end
        owner_inc = OW'((int'(owner_q) + 1) % NUM_MASTERS);
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        rr_ptr_d      = rr_ptr_q;
        timer_d       = timer_q;
        case (state_q)
            S_IDLE: begin
                owner_d        = any_req ? winner : OW'(PARK_MASTER);
                gnt_d          = '1;
                gnt_d[owner_d] = 1'b0;
                owner_valid_d  = 1'b1;
                timer_d        = '0;
                state_d        = S_GNT;
            end
            S_GNT: begin
                if (txn_start) begin
                    state_d  = S_BUSY;
                    rr_ptr_d = owner_inc;
                    timer_d  = '0;
                end else if (req[owner_q] && other_req) begin
                    gnt_d         = '1;
                    owner_valid_d = 1'b0;
                    state_d       = S_IDLE;
                end else if (bus_idle && other_req) begin
                    if (timer_q == TW'(GNT_TIMEOUT - 1)) begin
                        gnt_d         = '1;
                        owner_valid_d = 1'b0;
                        rr_ptr_d      = owner_inc;
                        state_d       = S_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end else begin
                    timer_d = '0;
                end
            end
            S_BUSY: begin
                // The owner keeps the bus under its latency timer; only GNT# is withdrawn.
                if (other_req && owner_valid_q) begin
                    gnt_d         = '1;
                    owner_valid_d = 1'b0;
                end
                if (bus_idle) begin
                    timer_d = '0;
                    state_d = owner_valid_d ? S_GNT : S_IDLE;
                end
            end
            default: begin
                gnt_d         = '1;
                owner_valid_d = 1'b0;
                state_d       = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            gnt_q         <= '1;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            bus_busy_q    <= 1'b0;
            rr_ptr_q      <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            bus_busy_q    <= ~frame | ~irdy;
            rr_ptr_q      <= rr_ptr_d;
            timer_q       <= timer_d;
        end
    end

    assign gnt         = gnt_q;
    assign owner       = owner_q;
    assign owner_valid = owner_valid_q;
    assign bus_busy    = bus_busy_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Self-checking bench for pci_bus_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for round-robin, timeout, hidden arbitration and async reset.
module tb_pci_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       frame;
    logic       irdy;
    logic [1:0] owner;
    logic       owner_valid;
    logic       bus_busy;

    int checks = 0;
    int errors = 0;

    pci_bus_arbiter #(
        .NUM_MASTERS(4),
        .PARK_MASTER(0),
        .GNT_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .frame      (frame),
        .irdy       (irdy),
        .owner      (owner),
        .owner_valid(owner_valid),
        .bus_busy   (bus_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       frm;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       valid;
        logic       busy;
    } vec_t;

    vec_t vecs [13];

    // Drive one cycle of inputs, let the next rising edge sample them, then settle.
    task automatic applyStimulus(input logic [3:0] r, input logic f, input logic i);
        req   = r;
        frame = f;
        irdy  = i;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic doReset();
        rst   = 1'b0;
        req   = 4'b1111;
        frame = 1'b1;
        irdy  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_gnt",   8'(gnt), 8'h0f);
        checkOutput("rst_owner", 8'(owner), 8'h00);
        checkOutput("rst_valid", 8'(owner_valid), 8'h00);
        checkOutput("rst_busy",  8'(bus_busy), 8'h00);
        rst = 1'b1;
        #1;
        checkOutput("post_rst_gnt", 8'(gnt), 8'h0f);
    endtask

    // At no sampled moment may two GNT# lines be low together.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            if ($countones(~gnt) > 1) begin
                errors++;
                $display("[TB] FAIL onehot_gnt: got %b expected at most one low bit", gnt);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expOrder [4];
        int onesSeen;
        int waited;

        //           req      frm   rdy   gnt      own   v     busy
        vecs[0]  = '{4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0};
        vecs[1]  = '{4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0};
        vecs[2]  = '{4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0};
        vecs[3]  = '{4'b1011, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b1, 1'b0};
        vecs[5]  = '{4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b1, 1'b0};
        vecs[6]  = '{4'b1011, 1'b0, 1'b1, 4'b1011, 2'd2, 1'b1, 1'b1};
        vecs[7]  = '{4'b1011, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b1};
        vecs[8]  = '{4'b1011, 1'b1, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b1};
        vecs[9]  = '{4'b1111, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b1, 1'b0};
        vecs[10] = '{4'b1111, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b1, 1'b0};
        vecs[11] = '{4'b1110, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0, 1'b0};
        vecs[12] = '{4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0};

        $display("[TB] vector table");
        doReset();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].req, vecs[i].frm, vecs[i].rdy);
            checkOutput($sformatf("vec%0d_gnt", i),   8'(gnt),         8'(vecs[i].gnt));
            checkOutput($sformatf("vec%0d_owner", i), 8'(owner),       8'(vecs[i].owner));
            checkOutput($sformatf("vec%0d_valid", i), 8'(owner_valid), 8'(vecs[i].valid));
            checkOutput($sformatf("vec%0d_busy", i),  8'(bus_busy),    8'(vecs[i].busy));
        end

        $display("[TB] round-robin between masters 1 and 3");
        doReset();
        expOrder = '{1, 3, 1, 3};
        onesSeen = 0;
        for (int g = 0; g < 4; g++) begin
            waited = 0;
            while (owner_valid !== 1'b1 && waited < 8) begin
                applyStimulus(4'b0101, 1'b1, 1'b1);
                if (gnt === 4'b1111) onesSeen++;
                waited++;
            end
            checkOutput($sformatf("rr%0d_valid", g), 8'(owner_valid), 8'h01);
            checkOutput($sformatf("rr%0d_owner", g), 8'(owner), 8'(expOrder[g]));
            if (g > 0) begin
                checks++;
                if (onesSeen < 1) begin
                    errors++;
                    $display("[TB] FAIL rr%0d_gap: got %0d idle clocks expected at least 1", g, onesSeen);
                end
            end
            onesSeen = 0;
            applyStimulus(4'b0101, 1'b0, 1'b0);
            applyStimulus(4'b0101, 1'b1, 1'b0);
            if (gnt === 4'b1111) onesSeen++;
            applyStimulus(4'b0101, 1'b1, 1'b1);
            if (gnt === 4'b1111) onesSeen++;
        end

        $display("[TB] grant timeout on master 2");
        doReset();
        applyStimulus(4'b1011, 1'b1, 1'b1);
        checkOutput("to_first_gnt", 8'(gnt), 8'h0b);
        waited = 1;
        for (int c = 0; c < 40 && gnt === 4'b1011; c++) begin
            applyStimulus(4'b1001, 1'b1, 1'b1);
            if (gnt === 4'b1011) waited++;
        end
        checkOutput("to_hold_clocks", 8'(waited), 8'd16);
        checkOutput("to_release_gnt", 8'(gnt), 8'h0f);
        applyStimulus(4'b1001, 1'b1, 1'b1);
        checkOutput("to_next_gnt",   8'(gnt), 8'h0d);
        checkOutput("to_next_owner", 8'(owner), 8'h01);

        $display("[TB] hidden arbitration during master 1 burst");
        doReset();
        applyStimulus(4'b1101, 1'b1, 1'b1);
        checkOutput("ha_grant", 8'(gnt), 8'h0d);
        applyStimulus(4'b1101, 1'b0, 1'b0);
        checkOutput("ha_start_gnt", 8'(gnt), 8'h0d);
        applyStimulus(4'b0101, 1'b0, 1'b0);
        checkOutput("ha_release_gnt", 8'(gnt), 8'h0f);
        applyStimulus(4'b0101, 1'b0, 1'b0);
        checkOutput("ha_burst_gnt", 8'(gnt), 8'h0f);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        checkOutput("ha_last_busy", 8'(bus_busy), 8'h01);
        applyStimulus(4'b0101, 1'b1, 1'b1);
        checkOutput("ha_idle_gnt",  8'(gnt), 8'h0f);
        checkOutput("ha_idle_busy", 8'(bus_busy), 8'h00);
        applyStimulus(4'b0101, 1'b1, 1'b1);
        checkOutput("ha_next_gnt",   8'(gnt), 8'h07);
        checkOutput("ha_next_owner", 8'(owner), 8'h03);

        $display("[TB] asynchronous reset mid-transaction");
        doReset();
        applyStimulus(4'b1101, 1'b1, 1'b1);
        applyStimulus(4'b1101, 1'b0, 1'b0);
        checkOutput("ar_pre_owner", 8'(owner), 8'h01);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("ar_gnt",   8'(gnt), 8'h0f);
        checkOutput("ar_valid", 8'(owner_valid), 8'h00);
        checkOutput("ar_owner", 8'(owner), 8'h00);
        checkOutput("ar_busy",  8'(bus_busy), 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 4'b1111;
        frame = 1'b1;
        irdy = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
